// File: rtl/smoldvi_scanout_ctrl.sv
// Scanout scheduler: burst prefetch into a show-ahead pixel FIFO,
// one pop per rgb_rdy, position kept aligned across underflow.
module smoldvi_scanout_ctrl #(
   parameter int          H_PIXELS         = 640,
   parameter int          V_LINES          = 480,
   parameter int          BURST_LEN        = 8,
   parameter int          FIFO_DEPTH       = 32,
   parameter int          ADDR_W           = 20,
   parameter logic [23:0] UNDERFLOW_COLOUR = 24'hff00ff
) (
   input  logic                          clk_pix,
   input  logic                          rst,
   input  logic                          en,
   input  logic [ADDR_W-1:0]             fb_base,
   input  logic                          rgb_rdy,
   output logic [7:0]                    r,
   output logic [7:0]                    g,
   output logic [7:0]                    b,
   output logic                          fetch_req,
   output logic [ADDR_W-1:0]             fetch_addr,
   input  logic                          fetch_ack,
   input  logic                          pix_valid,
   input  logic [23:0]                   pix_data,
   output logic                          frame_start,
   output logic                          underflow,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int FRAME = H_PIXELS * V_LINES;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int LW    = PW + 1;
   localparam int CW    = $clog2(FRAME + 1);
   localparam int BW    = $clog2(BURST_LEN + 1);

   typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;

   state_t              state;
   logic [23:0]         mem [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [CW-1:0]       fetch_cnt;
   logic [CW-1:0]       consume_cnt;
   logic [CW-1:0]       debt;
   logic [BW-1:0]       beats_left;
   logic [ADDR_W-1:0]   base_lat;
   logic [ADDR_W-1:0]   req_addr;
   logic [LW-1:0]       level_nxt;
   logic [23:0]         head;
   logic                beat;
   logic                uf;
   logic                pop;
   logic                discard;
   logic                debt_dec;
   logic                push;
   logic                credit_ok;
   logic                first;

   always_comb begin
      beat      = (state == DATA || state == DRAIN)
                  && pix_valid && beats_left != '0;
      uf        = rgb_rdy && level == '0;
      pop       = rgb_rdy && level != '0;
      debt_dec  = beat && state != DRAIN && (debt != '0 || uf);
      discard   = beat && (state == DRAIN || debt != '0 || uf);
      push      = beat && !discard;
      level_nxt = level + LW'(push) - LW'(pop);
      credit_ok = (int'(level_nxt) + BURST_LEN) <= FIFO_DEPTH;
      first     = fetch_cnt == '0;
      req_addr  = first ? fb_base : base_lat + ADDR_W'(fetch_cnt);
      head      = (level != '0) ? mem[rd_ptr] : UNDERFLOW_COLOUR;
   end

   assign {r, g, b} = head;

   always_ff @(posedge clk_pix) begin
      if (push) mem[wr_ptr] <= pix_data;
   end

   always_ff @(posedge clk_pix) begin
      if (rst) begin
         state       <= IDLE;
         fetch_req   <= 1'b0;
         fetch_addr  <= '0;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
         level       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fetch_cnt   <= '0;
         consume_cnt <= '0;
         debt        <= '0;
         beats_left  <= '0;
         base_lat    <= '0;
      end else begin
         frame_start <= 1'b0;
         level       <= level_nxt;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (beat) beats_left <= beats_left - BW'(1);
         if (uf) underflow <= 1'b1;
         if (rgb_rdy) begin
            consume_cnt <= (consume_cnt == CW'(FRAME - 1))
                           ? '0 : consume_cnt + CW'(1);
         end
         // debt counts underflowed positions whose beats are still due
         if (uf && !debt_dec) begin
            if (debt != CW'(FRAME)) debt <= debt + CW'(1);
         end else if (!uf && debt_dec) begin
            debt <= debt - CW'(1);
         end
         unique case (state)
            IDLE: begin
               if (en && credit_ok) begin
                  state      <= REQ;
                  fetch_req  <= 1'b1;
                  fetch_addr <= req_addr;
                  if (first) base_lat <= fb_base;
               end else if (!en && level != '0) begin
                  state <= DRAIN;
               end
            end
            REQ: begin
               if (fetch_ack) begin
                  state       <= DATA;
                  fetch_req   <= 1'b0;
                  beats_left  <= BW'(BURST_LEN);
                  frame_start <= first;
                  fetch_cnt   <= (fetch_cnt == CW'(FRAME - BURST_LEN))
                                 ? '0 : fetch_cnt + CW'(BURST_LEN);
               end
            end
            DATA: begin
               if (!en) begin
                  state <= DRAIN;
               end else if (beat && beats_left == BW'(1)) begin
                  if (credit_ok) begin
                     state      <= REQ;
                     fetch_req  <= 1'b1;
                     fetch_addr <= req_addr;
                     if (first) base_lat <= fb_base;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            DRAIN: begin
               // flush only once the outstanding burst has fully arrived
               if (beats_left == '0) begin
                  state       <= IDLE;
                  level       <= '0;
                  wr_ptr      <= '0;
                  rd_ptr      <= '0;
                  fetch_cnt   <= '0;
                  consume_cnt <= '0;
                  debt        <= '0;
                  underflow   <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_smoldvi_scanout_ctrl.sv
// Bench for smoldvi_scanout_ctrl: random-gap memory responder and
// a position-based pixel scoreboard on a small frame.
module tb_smoldvi_scanout_ctrl;

   localparam int          H     = 16;
   localparam int          V     = 4;
   localparam int          BL    = 8;
   localparam int          DEPTH = 32;
   localparam int          AW    = 20;
   localparam int          FRAME = H * V;
   localparam int          FPB   = FRAME / BL;
   localparam logic [23:0] MAG   = 24'hff00ff;

   logic          clk_pix;
   logic          rst;
   logic          en;
   logic [AW-1:0] fb_base;
   logic          rgb_rdy;
   logic [7:0]    r;
   logic [7:0]    g;
   logic [7:0]    b;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic          fetch_ack;
   logic          pix_valid;
   logic [23:0]   pix_data;
   logic          frame_start;
   logic          underflow;
   logic [5:0]    level;

   int checks = 0;
   int errors = 0;

   smoldvi_scanout_ctrl #(
      .H_PIXELS(H), .V_LINES(V), .BURST_LEN(BL),
      .FIFO_DEPTH(DEPTH), .ADDR_W(AW), .UNDERFLOW_COLOUR(MAG)
   ) dut (
      .clk_pix(clk_pix), .rst(rst), .en(en), .fb_base(fb_base),
      .rgb_rdy(rgb_rdy), .r(r), .g(g), .b(b),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ack(fetch_ack), .pix_valid(pix_valid),
      .pix_data(pix_data), .frame_start(frame_start),
      .underflow(underflow), .level(level)
   );

   initial clk_pix = 1'b0;
   always #5 clk_pix = ~clk_pix;

   // memory contents: every address holds a distinct, non-magenta word
   function automatic logic [23:0] pixf(input logic [AW-1:0] a);
      return {4'h5, a};
   endfunction

   // shared model state
   logic [AW-1:0] base_q[$];
   int            ack_idx = 0;
   int            ack_cnt = 0;
   int            fs_exp = 0;
   int            fs_seen = 0;
   int            stall_next = 0;
   bit            gaps = 0;
   int            r_phase = 0;
   int            r_i = 0;
   logic [AW-1:0] r_addr;
   logic [AW-1:0] first_addr;
   int            cpos = 0;
   int            cframe = 0;
   bit            c_on = 0;
   int            c_mode = 2;
   bit            tog = 0;
   bit            allow_uf = 0;
   int            mag_seen = 0;
   int            good_seen = 0;

   // memory responder: acks requests, returns BL beats with random gaps
   initial begin
      logic [AW-1:0] expa;
      int            fpos;
      fetch_ack = 1'b0;
      pix_valid = 1'b0;
      pix_data  = '0;
      forever begin
         @(posedge clk_pix);
         #1;
         fetch_ack = 1'b0;
         pix_valid = 1'b0;
         if (rst) begin
            r_phase = 0;
            continue;
         end
         if (r_phase == 1 && r_i == BL) r_phase = 0;
         if (r_phase == 0 && fetch_req) begin
            if (stall_next > 0) begin
               stall_next--;
            end else if (!(gaps && $urandom_range(0, 2) == 0)) begin
               fetch_ack = 1'b1;
               fpos = ack_idx % FPB;
               if (fpos == 0) begin
                  base_q.push_back(fb_base);
                  expa = fb_base;
                  first_addr = fetch_addr;
                  fs_exp++;
               end else begin
                  expa = base_q[$] + AW'(fpos * BL);
               end
               checks++;
               assert (fetch_addr === expa) else begin
                  errors++;
                  $error("FAIL fetch_addr obs=%0h exp=%0h",
                         fetch_addr, expa);
               end
               r_addr  = fetch_addr;
               r_i     = 0;
               r_phase = 1;
               ack_idx++;
               ack_cnt++;
            end
         end else if (r_phase == 1) begin
            if (!gaps || $urandom_range(0, 3) != 0) begin
               pix_valid = 1'b1;
               pix_data  = pixf(r_addr + AW'(r_i));
               r_i++;
            end
         end
      end
   end

   // consumer + scoreboard: pixel at frame position p must be base+p
   initial begin
      logic [23:0] obs;
      logic [23:0] expv;
      bit          known;
      rgb_rdy = 1'b0;
      forever begin
         @(posedge clk_pix);
         #1;
         rgb_rdy = 1'b0;
         if (c_on && !rst) begin
            tog = ~tog;
            if (c_mode == 1 || tog) begin
               rgb_rdy = 1'b1;
               obs   = {r, g, b};
               known = cframe < base_q.size();
               expv  = known ? pixf(base_q[cframe] + AW'(cpos)) : MAG;
               if (obs === MAG) mag_seen++;
               else good_seen++;
               checks++;
               assert (obs === expv || (allow_uf && obs === MAG)) else begin
                  errors++;
                  $error("FAIL pixel f%0d p%0d obs=%0h exp=%0h",
                         cframe, cpos, obs, expv);
               end
               cpos++;
               if (cpos == FRAME) begin
                  cpos = 0;
                  cframe++;
               end
            end
         end
      end
   end

   // occupancy bound and frame_start pulse count
   initial begin
      forever begin
         @(posedge clk_pix);
         #1;
         if (!rst) begin
            if (frame_start === 1'b1) fs_seen++;
            checks++;
            assert (level <= 6'(DEPTH)) else begin
               errors++;
               $error("FAIL level_bound obs=%0d exp<=%0d", level, DEPTH);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_pix);
         #2;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
      end
   endtask

   initial begin
      int k;
      int reqs;
      int good0;
      int cf0;
      rst     = 1'b1;
      en      = 1'b0;
      fb_base = 20'h100;

      // reset state
      step(3);
      chk("rst_fetch_req", 32'(fetch_req), 0);
      chk("rst_fetch_addr", 32'(fetch_addr), 0);
      chk("rst_frame_start", 32'(frame_start), 0);
      chk("rst_underflow", 32'(underflow), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_rgb", 32'({r, g, b}), 32'(MAG));
      rst = 1'b0;

      // initial fill stops once credit runs out
      en = 1'b1;
      step(60);
      chk("fill_acks", 32'(ack_cnt), 4);
      chk("fill_level", 32'(level), 32'(DEPTH));
      chk("fill_req_low", 32'(fetch_req), 0);

      // steady scanout, two full frames with random memory timing
      gaps = 1;
      c_on = 1;
      c_mode = 2;
      step(2 * FRAME * 2 + 20);
      chk("steady_underflow", 32'(underflow), 0);
      chk("steady_magenta", 32'(mag_seen), 0);
      chk("steady_frame_start", 32'(fs_seen), 32'(fs_exp));

      // buffer swap mid-frame
      for (k = 0; k < 300; k++) begin
         step(1);
         if (cpos == 8) break;
      end
      chk("swap_wait", 32'(cpos), 8);
      cf0 = cframe;
      fb_base = 20'h8000;
      for (k = 0; k < 600; k++) begin
         step(1);
         if (cframe == cf0 + 2) break;
      end
      chk("swap_frames", 32'(cframe), 32'(cf0 + 2));
      chk("swap_first_addr", 32'(first_addr), 32'h8000);
      chk("swap_frame_start", 32'(fs_seen), 32'(fs_exp));

      // stalled ack with consumption running: underflow then realign
      allow_uf = 1;
      c_mode = 1;
      stall_next = 40;
      step(60);
      chk("stall_underflow", 32'(underflow), 1);
      chk("stall_magenta_seen", 32'(mag_seen > 0), 1);
      c_mode = 2;
      gaps = 0;
      step(300);
      allow_uf = 0;
      gaps = 1;
      good0 = good_seen;
      step(100);
      chk("realign_pixels", 32'(good_seen - good0 >= 40), 1);

      // disable with three beats of the burst still to come
      for (k = 0; k < 200; k++) begin
         step(1);
         if (r_phase == 1 && r_i == BL - 3) break;
      end
      chk("dis_wait", 32'(r_i), 32'(BL - 3));
      en = 1'b0;
      c_on = 0;
      reqs = 0;
      for (k = 0; k < 30; k++) begin
         step(1);
         if (fetch_req) reqs++;
      end
      chk("dis_no_req", 32'(reqs), 0);
      chk("dis_level", 32'(level), 0);
      chk("dis_underflow_clr", 32'(underflow), 0);
      chk("dis_beats_done", 32'(r_i), 32'(BL));
      base_q.delete();
      ack_idx = 0;
      cpos = 0;
      cframe = 0;
      first_addr = '1;
      en = 1'b1;
      for (k = 0; k < 50; k++) begin
         step(1);
         if (first_addr != 20'hfffff) break;
      end
      chk("reen_first_addr", 32'(first_addr), 32'h8000);
      step(60);
      c_on = 1;
      good0 = good_seen;
      step(100);
      chk("reen_pixels", 32'(good_seen - good0 >= 40), 1);

      // reset in the middle of a burst
      for (k = 0; k < 200; k++) begin
         step(1);
         if (r_phase == 1 && r_i == 3) break;
      end
      chk("rst_mid_wait", 32'(r_i), 3);
      rst = 1'b1;
      en = 1'b0;
      c_on = 0;
      step(1);
      chk("rst2_fetch_req", 32'(fetch_req), 0);
      chk("rst2_fetch_addr", 32'(fetch_addr), 0);
      chk("rst2_frame_start", 32'(frame_start), 0);
      chk("rst2_underflow", 32'(underflow), 0);
      chk("rst2_level", 32'(level), 0);
      chk("rst2_rgb", 32'({r, g, b}), 32'(MAG));
      rst = 1'b0;
      step(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
